hazard_stall_ctrl: RTL and testbench

Pipeline hazard and multdiv sequencing controller for the 5-stage processor; it sits beside the F/D, D/X and X/M latches and the execute-stage bypass selectors.
- Detects load-use hazards and freezes F/D while inserting one bubble into D/X.
- Sequences the multi-cycle multdiv unit: issues a one-cycle start pulse, freezes the front of the pipeline until the unit reports ready (or times out), then releases the result into X/M.

---
 rtl/hazard_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detection and multdiv start/wait/done sequencing.
// Define HAZ_PERF_CNT_EN to enable the stall/multdiv performance counters.
module hazard_stall_ctrl #(
  parameter int REG_W      = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] fd_rs,
  input  logic [REG_W-1:0] fd_rt,
  input  logic             fd_uses_rs,
  input  logic             fd_uses_rt,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             dx_is_load,
  input  logic             dx_is_mult,
  input  logic             dx_is_div,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic             stall_fd,
  output logic             hold_dx,
  output logic             bubble_dx,
  output logic             bubble_xm,
  output logic             ctrl_mult,
  output logic             ctrl_div,
  output logic             md_busy,
  output logic             md_done,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] md_ops
);

  localparam int TW = $clog2(MD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  cnt_q;
  logic           err_q;
  logic           md_req;
  logic           lu_hit;
  logic           rd_nz;
  logic           timeout;

  assign md_req  = dx_is_mult | dx_is_div;
  assign rd_nz   = |dx_rd;
  assign timeout = (cnt_q == TW'(MD_TIMEOUT - 1));
  assign lu_hit  = dx_is_load & rd_nz &
                   ((fd_uses_rs & (fd_rs == dx_rd)) |
                    (fd_uses_rt & (fd_rt == dx_rd)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_START) begin
        cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + TW'(1);
      end
      // Exception is sampled with ready; a timeout counts as an error
      if (state_q == S_WAIT && state_d == S_DONE) begin
        err_q <= md_ready ? md_exception : 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    stall_fd  = 1'b0;
    hold_dx   = 1'b0;
    bubble_dx = 1'b0;
    bubble_xm = 1'b0;
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    md_busy   = 1'b0;
    md_done   = 1'b0;
    md_err    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (md_req) begin
          state_d = S_START;
        end else if (lu_hit) begin
          stall_fd  = 1'b1;
          bubble_dx = 1'b1;
        end
      end
      S_START: begin
        state_d   = S_WAIT;
        ctrl_mult = dx_is_mult;
        ctrl_div  = dx_is_div & ~dx_is_mult;
        stall_fd  = 1'b1;
        hold_dx   = 1'b1;
        bubble_xm = 1'b1;
        md_busy   = 1'b1;
      end
      S_WAIT: begin
        if (md_ready || timeout) begin
          state_d = S_DONE;
        end
        stall_fd  = 1'b1;
        hold_dx   = 1'b1;
        bubble_xm = 1'b1;
        md_busy   = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        md_done = 1'b1;
        md_err  = err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      md_ops       <= '0;
    end else begin
      if (stall_fd && !(&stall_cycles)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (md_done && !(&md_ops)) begin
        md_ops <= md_ops + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cycles = '0;
  assign md_ops       = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed per-cycle vectors.
// Define HAZ_PERF_CNT_EN to expect live performance counters.
module tb_hazard_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  fd_rs = '0;
  logic [4:0]  fd_rt = '0;
  logic        fd_uses_rs = 1'b0;
  logic        fd_uses_rt = 1'b0;
  logic [4:0]  dx_rd = '0;
  logic        dx_is_load = 1'b0;
  logic        dx_is_mult = 1'b0;
  logic        dx_is_div = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic        stall_fd, hold_dx, bubble_dx, bubble_xm;
  logic        ctrl_mult, ctrl_div, md_busy, md_done, md_err;
  logic [15:0] stall_cycles, md_ops;

  hazard_stall_ctrl #(
    .REG_W(5),
    .MD_TIMEOUT(40),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fd_rs(fd_rs),
    .fd_rt(fd_rt),
    .fd_uses_rs(fd_uses_rs),
    .fd_uses_rt(fd_uses_rt),
    .dx_rd(dx_rd),
    .dx_is_load(dx_is_load),
    .dx_is_mult(dx_is_mult),
    .dx_is_div(dx_is_div),
    .md_ready(md_ready),
    .md_exception(md_exception),
    .stall_fd(stall_fd),
    .hold_dx(hold_dx),
    .bubble_dx(bubble_dx),
    .bubble_xm(bubble_xm),
    .ctrl_mult(ctrl_mult),
    .ctrl_div(ctrl_div),
    .md_busy(md_busy),
    .md_done(md_done),
    .md_err(md_err),
    .stall_cycles(stall_cycles),
    .md_ops(md_ops)
  );

  always #5 clock = ~clock;

  // Output bits: {stall,hold,bub_dx,bub_xm,cmul,cdiv,busy,done,err}
  localparam logic [8:0] Z  = 9'b000000000;
  localparam logic [8:0] LU = 9'b101000000;
  localparam logic [8:0] SM = 9'b110110100;
  localparam logic [8:0] SD = 9'b110101100;
  localparam logic [8:0] WT = 9'b110100100;
  localparam logic [8:0] DN = 9'b000000010;
  localparam logic [8:0] DE = 9'b000000011;

  // Controls: {reset,load,mult,div,ready,exception}
  localparam logic [5:0] R   = 6'b100000;
  localparam logic [5:0] LD  = 6'b010000;
  localparam logic [5:0] MU  = 6'b001000;
  localparam logic [5:0] DV  = 6'b000100;
  localparam logic [5:0] RDY = 6'b000010;
  localparam logic [5:0] EX  = 6'b000001;

  typedef struct {
    string       nm;
    logic [8:0]  e;
    logic [15:0] sc;
    logic [15:0] ops;
  } exp_t;

  exp_t        q[$];
  exp_t        x;
  int          vecs = 0;
  int          bad = 0;
  logic [15:0] exp_sc = '0;
  logic [15:0] exp_ops = '0;
  logic [8:0]  act;

  assign act = {stall_fd, hold_dx, bubble_dx, bubble_xm,
                ctrl_mult, ctrl_div, md_busy, md_done, md_err};

  always @(negedge clock) begin
    if (q.size() > 0) begin
      x = q.pop_front();
      vecs++;
      if (act !== x.e || stall_cycles !== x.sc || md_ops !== x.ops) begin
        bad++;
        $display("FAIL %s: got %b sc=%0d ops=%0d, want %b sc=%0d ops=%0d",
                 x.nm, act, stall_cycles, md_ops, x.e, x.sc, x.ops);
      end
    end
  end

  task automatic step(input string nm, input logic [5:0] c,
                      input logic [8:0] e,
                      input logic [4:0] rd = 5'd0,
                      input logic [4:0] rs = 5'd0,
                      input logic [4:0] rt = 5'd0,
                      input logic urs = 1'b0,
                      input logic urt = 1'b0);
    exp_t v;
    @(posedge clock);
    #1;
    reset        = c[5];
    dx_is_load   = c[4];
    dx_is_mult   = c[3];
    dx_is_div    = c[2];
    md_ready     = c[1];
    md_exception = c[0];
    dx_rd        = rd;
    fd_rs        = rs;
    fd_rt        = rt;
    fd_uses_rs   = urs;
    fd_uses_rt   = urt;
`ifdef HAZ_PERF_CNT_EN
    if (c[5]) begin
      exp_sc  = '0;
      exp_ops = '0;
    end
    v.sc  = exp_sc;
    v.ops = exp_ops;
    if (e[8]) exp_sc = exp_sc + 16'd1;
    if (e[1]) exp_ops = exp_ops + 16'd1;
`else
    v.sc  = '0;
    v.ops = '0;
`endif
    v.nm = nm;
    v.e  = e;
    q.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step("rst", R, Z);
    step("idle", 6'b0, Z);

    step("lu_rs", LD, LU, 5, 5, 0, 1, 0);
    step("lu_bubbled", 6'b0, Z, 0, 5, 0, 1, 0);
    step("lu_rd0", LD, Z, 0, 0, 0, 1, 0);
    step("lu_rt", LD, LU, 7, 1, 7, 0, 1);
    step("lu_nouse", LD, Z, 7, 7, 7, 0, 0);
    step("lu_clr", 6'b0, Z);

    step("mul_idle", MU, Z);
    step("mul_start", MU, SM);
    repeat (31) step("mul_wait", MU, WT);
    step("mul_rdy", MU | RDY, WT);
    step("mul_done", MU, DN);
    step("b2b_idle", DV, Z);
    step("b2b_start", DV, SD);
    step("b2b_rdy", DV | RDY, WT);
    step("b2b_done", DV, DN);
    step("b2b_idle2", 6'b0, Z);

    step("dz_idle", DV, Z);
    step("dz_start_rdy_ign", DV | RDY | EX, SD);
    step("dz_w1", DV, WT);
    step("dz_w2", DV, WT);
    step("dz_w3_exc", DV | RDY | EX, WT);
    step("dz_done", DV, DE);
    step("dz_idle2", 6'b0, Z);

    step("to_idle", DV, Z);
    step("to_start", DV, SD);
    repeat (40) step("to_wait", DV, WT);
    step("to_done", DV, DE);
    step("to_released", LD, LU, 3, 3, 0, 1, 0);
    step("to_clr", 6'b0, Z);

    step("both_idle", MU | DV, Z);
    step("both_start", MU | DV, SM);
    step("both_rdy", MU | DV | RDY, WT);
    step("both_done", MU | DV, DN);
    step("both_idle2", 6'b0, Z);

    step("rm_idle", MU, Z);
    step("rm_start", MU, SM);
    step("rm_w1", MU, WT);
    step("rm_w2", MU, WT);
    step("rm_reset", R | MU, Z);
    step("rm_release", 6'b0, Z);
    step("rm_no_done", 6'b0, Z);

    step("pri_idle", LD | MU, Z, 5, 5, 0, 1, 0);
    step("pri_start", LD | MU, SM, 5, 5, 0, 1, 0);
    repeat (9) step("pri_wait", MU, WT);
    step("pri_rdy", MU | RDY, WT);
    step("pri_done", MU, DN);
    step("perf_chk", 6'b0, Z);
    step("perf_hold", 6'b0, Z);

    @(posedge clock);
    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
    $finish;
  end

endmodule
